// File: rtl/textlcd_buf_ctrl_if.sv
// Buffer write / clear port of the character LCD controller.
// The application drives the write side, the controller reports busy.
interface textlcd_buf_ctrl_if #(
    parameter int AW = 5
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          clr_req;
    logic          busy;

    modport master (
        output wr_en, wr_addr, wr_data, clr_req,
        input  busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req,
        output busy
    );
endinterface

// File: rtl/textlcd_buf_ctrl.sv
// HD44780-class 8-bit write-only LCD controller with LINES x COLS buffer.
// Optional cursor support is enabled by defining TEXTLCD_CURSOR_EN.
module textlcd_buf_ctrl #(
    parameter  int COLS         = 16,
    parameter  int LINES        = 2,
    parameter  int E_HIGH       = 2,
    parameter  int INIT_WAIT    = 70,
    parameter  int CMD_WAIT     = 30,
    parameter  int CLR_WAIT     = 200,
    parameter  int REFRESH_WAIT = 400,
    localparam int N            = LINES * COLS,
    localparam int AW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
`ifdef TEXTLCD_CURSOR_EN
    input  logic [AW-1:0] cursor_pos,
    input  logic          cursor_on,
`endif
    textlcd_buf_ctrl_if.slave bus,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic [7:0]    LCD_DATA
);

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_FUNC, S_DISP, S_ENTRY, S_CLEAR,
        S_LADDR, S_CHAR, S_CURSOR, S_REFRESH
    } state_t;

    typedef enum logic [1:0] {P_SETUP, P_HIGH, P_WAIT} phase_t;

    localparam logic [7:0] FUNC_CMD = (LINES == 2) ? 8'h3C : 8'h34;

    state_t        state, n_state;
    phase_t        ph;
    logic [15:0]   cnt, wait_cnt;
    logic          line, n_line, tgt_line;
    logic [5:0]    col, n_col;
    logic [7:0]    n_data, disp_cmd;
    logic          n_rs, n_xfer, to_laddr;
    logic          done, pend, busy_q, ready, clr_merge;
    logic [AW-1:0] rd_idx;
    logic [7:0]    mem [N];

`ifdef TEXTLCD_CURSOR_EN
    logic       cur_q;
    logic [7:0] cur_addr;
    assign disp_cmd = cursor_on ? 8'h0F : 8'h0C;
    assign cur_addr = (int'(cursor_pos) >= COLS)
                    ? 8'(int'(cursor_pos) - COLS + 'h40)
                    : 8'(cursor_pos);
`else
    assign disp_cmd = 8'h0C;
`endif

    assign LCD_RW   = 1'b0;
    assign bus.busy = busy_q;
    assign done     = (ph == P_WAIT) && (cnt == 16'd0);
    assign wait_cnt = (state == S_CLEAR)
                    ? 16'(CMD_WAIT + CLR_WAIT - 1)
                    : 16'(CMD_WAIT - 1);

    // Successor state and the transfer it starts, taken when done is high
    always_comb begin
        n_state  = state;
        n_data   = LCD_DATA;
        n_rs     = 1'b0;
        n_line   = line;
        n_col    = col;
        n_xfer   = 1'b1;
        to_laddr = 1'b0;
        tgt_line = 1'b0;
        rd_idx   = '0;
        case (state)
            S_INIT_WAIT: begin
                n_state = S_FUNC;
                n_data  = FUNC_CMD;
            end
            S_FUNC: begin
                n_state = S_DISP;
                n_data  = disp_cmd;
            end
            S_DISP: begin
                if (ready) begin
                    to_laddr = 1'b1;
                end else begin
                    n_state = S_ENTRY;
                    n_data  = 8'h06;
                end
            end
            S_ENTRY: begin
                n_state = S_CLEAR;
                n_data  = 8'h01;
            end
            S_CLEAR: to_laddr = 1'b1;
            S_LADDR: begin
                n_state = S_CHAR;
                n_col   = 6'd0;
                n_rs    = 1'b1;
            end
            S_CHAR: begin
                if (col != 6'(COLS - 1)) begin
                    n_col = col + 6'd1;
                    n_rs  = 1'b1;
                end else if (int'(line) != LINES - 1) begin
                    to_laddr = 1'b1;
                    tgt_line = 1'b1;
                end else begin
`ifdef TEXTLCD_CURSOR_EN
                    n_state = S_CURSOR;
                    n_data  = 8'h80 | cur_addr;
`else
                    n_state = S_REFRESH;
                    n_xfer  = 1'b0;
`endif
                end
            end
            S_CURSOR: begin
                n_state = S_REFRESH;
                n_xfer  = 1'b0;
            end
            S_REFRESH: begin
`ifdef TEXTLCD_CURSOR_EN
                if (cursor_on != cur_q) begin
                    n_state = S_DISP;
                    n_data  = disp_cmd;
                end else begin
                    to_laddr = 1'b1;
                end
`else
                to_laddr = 1'b1;
`endif
            end
            default: ;
        endcase
        // A pending clear is slotted in ahead of any line address
        if (to_laddr) begin
            if (pend) begin
                n_state = S_CLEAR;
                n_data  = 8'h01;
                n_line  = 1'b0;
            end else begin
                n_state = S_LADDR;
                n_line  = tgt_line;
                n_data  = tgt_line ? 8'hC0 : 8'h80;
            end
        end
        rd_idx = AW'(int'(n_line) * COLS + int'(n_col));
        if (n_state == S_CHAR) n_data = mem[rd_idx];
    end

    assign clr_merge = (state == S_CLEAR && !done)
                     || (done && n_state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= S_INIT_WAIT;
            ph       <= P_WAIT;
            cnt      <= 16'(INIT_WAIT - 1);
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
            line     <= 1'b0;
            col      <= 6'd0;
            pend     <= 1'b0;
            busy_q   <= 1'b1;
            ready    <= 1'b0;
`ifdef TEXTLCD_CURSOR_EN
            cur_q    <= 1'b0;
`endif
        end else begin
            case (ph)
                P_SETUP: begin
                    LCD_E <= 1'b1;
                    ph    <= P_HIGH;
                    cnt   <= 16'(E_HIGH - 1);
                end
                P_HIGH: begin
                    if (cnt == 16'd0) begin
                        LCD_E <= 1'b0;
                        ph    <= P_WAIT;
                        cnt   <= wait_cnt;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                P_WAIT: if (cnt != 16'd0) cnt <= cnt - 16'd1;
                default: ;
            endcase
            if (done) begin
                state <= n_state;
                line  <= n_line;
                col   <= n_col;
                if (n_xfer) begin
                    LCD_RS   <= n_rs;
                    LCD_DATA <= n_data;
                    ph       <= P_SETUP;
                end else begin
                    cnt <= 16'(REFRESH_WAIT - 1);
                end
                if (state == S_CLEAR) begin
                    busy_q <= 1'b0;
                    ready  <= 1'b1;
                end
                if (n_state == S_CLEAR) pend <= 1'b0;
`ifdef TEXTLCD_CURSOR_EN
                if (n_state == S_DISP) cur_q <= cursor_on;
`endif
            end
            if (bus.clr_req && !clr_merge) begin
                pend   <= 1'b1;
                busy_q <= 1'b1;
            end
        end
    end

    // Clear beats a same-cycle write; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (resetn || bus.clr_req) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'h20;
        end else if (bus.wr_en && int'(bus.wr_addr) < N) begin
            mem[AW'(bus.wr_addr)] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_textlcd_buf_ctrl.sv
// Directed bench: default 16x2 controller plus an 8x1 variant.
// Transfers are logged on each E rise and compared against expectations.
module tb_textlcd_buf_ctrl;

    localparam int EH  = 2;
    localparam int IW  = 70;
    localparam int CW  = 30;
    localparam int LW  = 200;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic e0, rs0, rw0, e1, rs1, rw1;
    logic [7:0] d0, d1;

    int n_chk = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    int unsigned rst_cyc0 = 0;

    int unsigned log0[$], ecyc0[$], bf0[$], log1[$];
    int hcnt0 = 0;
    logic ep0 = 1'b0, bp0 = 1'b0, ep1 = 1'b0;

    textlcd_buf_ctrl_if #(.AW(5)) b0 ();
    textlcd_buf_ctrl_if #(.AW(4)) b1 ();

    textlcd_buf_ctrl dut0 (
        .clk      (clk),
        .resetn   (rst0),
        .bus      (b0),
        .LCD_E    (e0),
        .LCD_RS   (rs0),
        .LCD_RW   (rw0),
        .LCD_DATA (d0)
    );

    textlcd_buf_ctrl #(
        .COLS(8), .LINES(1), .E_HIGH(2), .INIT_WAIT(10),
        .CMD_WAIT(4), .CLR_WAIT(8), .REFRESH_WAIT(20)
    ) dut1 (
        .clk      (clk),
        .resetn   (rst1),
        .bus      (b1),
        .LCD_E    (e1),
        .LCD_RS   (rs1),
        .LCD_RW   (rw1),
        .LCD_DATA (d1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic int unsigned at(input int unsigned q[$],
                                       input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst0) rst_cyc0 = cyc;
    end

    always @(negedge clk) begin
        if (rst0) begin
            hcnt0 = 0;
            ep0 = 1'b0;
        end else begin
            if (e0 && !ep0) begin
                log0.push_back({23'd0, rs0, d0});
                ecyc0.push_back(cyc);
            end
            if (e0) begin
                hcnt0++;
            end else if (hcnt0 != 0) begin
                chk("e_width", hcnt0, EH);
                chk("hold", {23'd0, rs0, d0}, log0[$]);
                hcnt0 = 0;
            end
            ep0 = e0;
        end
        if (bp0 && !b0.busy) bf0.push_back(cyc);
        bp0 = b0.busy;
    end

    always @(negedge clk) begin
        if (!rst1 && e1 && !ep1) log1.push_back({23'd0, rs1, d1});
        ep1 = rst1 ? 1'b0 : e1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_log0(input int n);
        int k = 0;
        while (log0.size() < n && k < 5000) begin
            tick(1);
            k++;
        end
        chk("wait_log0", 32'(log0.size() >= n), 1);
    endtask

    task automatic wait_log1(input int n);
        int k = 0;
        while (log1.size() < n && k < 5000) begin
            tick(1);
            k++;
        end
        chk("wait_log1", 32'(log1.size() >= n), 1);
    endtask

    task automatic wr0(input int a, input logic [7:0] d);
        b0.wr_en = 1'b1;
        b0.wr_addr = 5'(a);
        b0.wr_data = d;
        tick(1);
        b0.wr_en = 1'b0;
    endtask

    task automatic wr1(input int a, input logic [7:0] d);
        b1.wr_en = 1'b1;
        b1.wr_addr = 4'(a);
        b1.wr_data = d;
        tick(1);
        b1.wr_en = 1'b0;
    endtask

    task automatic chk_run0(input string tag, input int from,
                            input int len, input int unsigned v);
        for (int i = from; i < from + len; i++)
            chk(tag, at(log0, i), v);
    endtask

    int unsigned init0[5] = '{'h03C, 'h00C, 'h006, 'h001, 'h080};
    int unsigned init1[5] = '{'h034, 'h00C, 'h006, 'h001, 'h080};

    initial begin
        b0.wr_en = 1'b0; b0.wr_addr = '0;
        b0.wr_data = '0; b0.clr_req = 1'b0;
        b1.wr_en = 1'b0; b1.wr_addr = '0;
        b1.wr_data = '0; b1.clr_req = 1'b0;
        tick(3);
        chk("rst_e", e0, 0);
        chk("rst_rs", rs0, 0);
        chk("rst_rw", rw0, 0);
        chk("rst_data", d0, 0);
        chk("rst_busy", b0.busy, 1);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // 8x1 variant: function set, single line, ignored index 8
        wait_log1(5);
        for (int i = 0; i < 5; i++)
            chk("l1_init", at(log1, i), init1[i]);
        wr1(7, 8'h37);
        wr1(8, 8'h58);
        wait_log1(15);
        for (int i = 5; i < 12; i++)
            chk("l1_blank", at(log1, i), 'h120);
        chk("l1_idx7", at(log1, 12), 'h137);
        chk("l1_wrap", at(log1, 13), 'h080);
        chk("l1_next", at(log1, 14), 'h120);

        // 16x2 init sequence and first pass
        wait_log0(21);
        for (int i = 0; i < 5; i++)
            chk("init_seq", at(log0, i), init0[i]);
        chk_run0("pass1_l0", 5, 16, 'h120);
        chk("init_idle", at(ecyc0, 0) - rst_cyc0, IW + 1);
        chk("xfer_gap", at(ecyc0, 1) - at(ecyc0, 0),
            1 + EH + CW);
        chk("busy_fall", at(bf0, 0) - at(ecyc0, 3),
            EH + CW + LW);
        chk("busy_low", b0.busy, 0);

        wait_log0(38);
        chk("pass1_l1", at(log0, 21), 'h0C0);
        chk_run0("pass1_l1c", 22, 16, 'h120);
        tick(40);
        wr0(0, 8'h48);
        wr0(1, 8'h49);
        wait_log0(41);
        wr0(17, 8'h41);
        wait_log0(72);
        chk("p2_addr", at(log0, 38), 'h080);
        chk("p2_h", at(log0, 39), 'h148);
        chk("p2_i", at(log0, 40), 'h149);
        chk_run0("p2_l0", 41, 14, 'h120);
        chk("p2_l1", at(log0, 55), 'h0C0);
        chk("p2_c16", at(log0, 56), 'h120);
        chk("p2_c17", at(log0, 57), 'h141);
        chk_run0("p2_l1r", 58, 14, 'h120);

        // Clear with a colliding write during refresh idle
        tick(40);
        b0.clr_req = 1'b1;
        b0.wr_en = 1'b1;
        b0.wr_addr = 5'd2;
        b0.wr_data = 8'h5A;
        tick(1);
        b0.clr_req = 1'b0;
        b0.wr_en = 1'b0;
        chk("clr_busy", b0.busy, 1);
        wait_log0(93);
        chk("clr_cmd", at(log0, 72), 'h001);
        chk("clr_addr", at(log0, 73), 'h080);
        chk_run0("clr_l0", 74, 16, 'h120);
        chk("clr_l1", at(log0, 90), 'h0C0);
        chk("clr_c16", at(log0, 91), 'h120);
        chk("clr_c17", at(log0, 92), 'h120);
        chk("clr_bfall", at(bf0, 1) - at(ecyc0, 72),
            EH + CW + LW);
        chk("clr_gap", at(ecyc0, 73) - at(ecyc0, 72),
            1 + EH + CW + LW);

        // Reset in the middle of a character transfer
        wait_log0(96);
        chk("mid_char", at(log0, 95), 'h120);
        rst0 = 1'b1;
        tick(1);
        chk("mid_e", e0, 0);
        chk("mid_rs", rs0, 0);
        chk("mid_data", d0, 0);
        chk("mid_busy", b0.busy, 1);
        rst0 = 1'b0;
        wait_log0(98);
        chk("re_func", at(log0, 96), 'h03C);
        chk("re_disp", at(log0, 97), 'h00C);
        chk("re_idle", at(ecyc0, 96) - rst_cyc0, IW + 1);
        chk("rw0", rw0, 0);
        chk("rw1", rw1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/textlcd_buf_ctrl.md
Name: textlcd_buf_ctrl

Overview:
Parametrised HD44780-class character LCD controller using an 8-bit bus and write-only access.
- Holds a LINES x COLS character buffer that user logic writes through a simple single-cycle port.
- Runs the power-on init sequence, then continuously refreshes the panel from the buffer.
- Generates a real E strobe with configurable width; E is not tied to clk.
- Sits between application logic (counters, game state, messages) and the board LCD pins.

Parameters:
COLS, 16, characters per line (1..40)
LINES, 2, display lines (1 or 2)
E_HIGH, 2, clk cycles E is held high per transfer
INIT_WAIT, 70, clk cycles idle after reset before the first command
CMD_WAIT, 30, clk cycles E-low gap after each command or character transfer
CLR_WAIT, 200, extra clk cycles after a clear-display command
REFRESH_WAIT, 400, idle clk cycles between refresh passes

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-high reset (asserted = 1)
wr_en  in  1  buffer write strobe, single cycle
wr_addr  in  AW  buffer index = line*COLS + col; AW = $clog2(LINES*COLS)
wr_data  in  8  ASCII/CGROM code
clr_req  in  1  one-cycle pulse: blank buffer and clear panel
busy  out  1  high during init and while a clear is being serviced
LCD_E  out  1  enable strobe
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  always 0 after reset
LCD_DATA  out  8  bus data

Behaviour:
- Reset (resetn=1 at posedge clk):
  - State goes to S_INIT_WAIT.
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, busy=1.
  - Every buffer entry is set to 0x20; pending clear is dropped.
  - Reset mid-transfer aborts the transfer immediately with the same values.
- Transfer unit, used for every command and character:
  - Setup cycle: RS and DATA are driven, E=0.
  - E_HIGH cycles with E=1.
  - Wait cycles with E=0: CMD_WAIT, or CMD_WAIT+CLR_WAIT for a clear.
  - RS and DATA stay stable for the whole unit.
- FSM states:
  - S_INIT_WAIT: INIT_WAIT cycles idle.
  - S_FUNC: sends 0x3C if LINES=2, 0x34 if LINES=1.
  - S_DISP: sends 0x0C.
  - S_ENTRY: sends 0x06.
  - S_CLEAR: sends 0x01; busy drops to 0 at the end of its wait.
  - S_LADDR: sends 0x80 for line 0, 0xC0 for line 1.
  - S_CHAR: COLS data transfers for the current line, col 0..COLS-1.
  - After the last column of line LINES-1 go to S_REFRESH; otherwise go to S_LADDR of the next line.
  - S_REFRESH: REFRESH_WAIT cycles idle, then S_LADDR for line 0 (wrap).
- Init path: S_INIT_WAIT -> S_FUNC -> S_DISP -> S_ENTRY -> S_CLEAR -> S_LADDR.
- Buffer write:
  - wr_en with wr_addr < LINES*COLS updates the entry at the clock edge.
  - Writes are accepted in every state, including during busy.
  - wr_en with an out-of-range address is ignored.
- Buffer read timing:
  - The character is sampled in the S_CHAR setup cycle.
  - A write to the same index on that edge goes out on the next pass; the old value is sent this pass.
  - A write to an index not yet sent in the current pass appears this pass.
- clr_req:
  - Sets a pending flag and busy=1 on the next cycle.
  - The whole buffer is set to 0x20 on the same edge as clr_req is sampled.
  - If wr_en arrives in the same cycle, the clear wins and the write is dropped.
  - The pending clear is serviced at the next S_LADDR entry: S_CLEAR is inserted first, then S_LADDR restarts at line 0.
  - clr_req while a clear is already pending or executing is merged into it (no second clear).
- LCD_RW is never driven high after reset.

Optional Feature:
TEXTLCD_CURSOR_EN
- When defined, adds two inputs: cursor_pos (AW bits) and cursor_on (1 bit).
- S_DISP sends 0x0F when cursor_on=1, 0x0C when cursor_on=0.
- Each S_REFRESH entry first issues one address command (0x80 | DDRAM address of cursor_pos), then idles for REFRESH_WAIT.
- cursor_on changes take effect at the next pass via a re-issued display on/off command.
- When undefined, these ports do not exist and behaviour is exactly as above.

Test Plan:
- Reset, defaults:
  - Expect 70 idle cycles.
  - Then commands 0x3C, 0x0C, 0x06, 0x01, each with RS=0 and an E pulse 2 cycles wide.
  - busy falls after the 0x01 wait.
  - Next transfer is 0x80 followed by 16 transfers of 0x20 with RS=1.
- Write "HI" to indices 0 and 1 during S_REFRESH: next pass sends 0x80, 0x48, 0x49, then 14 transfers of 0x20.
- Write index 17 = 0x41 while line 0 is streaming: the same pass sends 0xC0, 0x20, 0x41 on line 1.
- clr_req with a simultaneous wr_en:
  - Buffer is all 0x20 and the write is dropped.
  - 0x01 is issued before the next line address.
  - busy stays high until CLR_WAIT+CMD_WAIT have elapsed.
- Reset asserted in the middle of a character transfer: next cycle E=0, DATA=0x00, RS=0, busy=1, and the init sequence restarts.
- LINES=1, COLS=8: function set is 0x34, there is no 0xC0 command, and each pass is 0x80 plus 8 characters; write at index 8 is ignored.
